serial_pattern_tx: RTL and testbench
====================================

// Module: serial_pattern_tx
// PURPOSE
//  Transmit end of the single-bit serial stream consumed by the team's sequence detectors.
//  Accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock on X with XValid.
//  Tallies transmitted 0s/1s; sticky Seen rises once >=MIN_ZEROS zeros and >=MIN_ONES ones have been sent.
//  Seen is the golden reference for checking a downstream detector's Z output.
// PARAMETERS
//  WIDTH      8  bits per loaded word (>=2)
//  MIN_ZEROS  2  zeros required before Seen asserts (>=1)
//  MIN_ONES   2  ones required before Seen asserts (>=1)
// PORTS
//  Clock   in   1      rising-edge clock
//  Resetn  in   1      reset, asynchronous, active-low
//  Load    in   1      word valid; accepted when Load && Ready
//  Data    in   WIDTH  word to transmit, sampled on acceptance
//  Clear   in   1      synchronous clear of tallies and Seen
//  Ready   out  1      block can accept a word (IDLE only)
//  X       out  1      serial bit
//  XValid  out  1      X carries a valid bit this cycle
//  Done    out  1      one-cycle pulse after last bit of a word
//  Seen    out  1      sticky: zero/one thresholds reached since reset/Clear
// BEHAVIOUR
//  - Reset (async, Resetn=0): state IDLE, shift reg 0, bit count 0, tallies 0.
//    Outputs: Ready=1, X=0, XValid=0, Done=0, Seen=0. Reset mid-word aborts the word; no Done.
//  - States:
//    - IDLE: Ready=1. On Load&&Ready: capture Data, count<=0, go SHIFT.
//    - SHIFT: Ready=0, XValid=1, X=current bit; shift each cycle, count++.
//      When count==WIDTH-1, go DONE after that bit.
//    - DONE: Done=1, XValid=0, Ready=0 for exactly one cycle, then IDLE.
//  - Latency: bit 0 appears on X the cycle after acceptance. A word occupies WIDTH+1 cycles after
//    accept, then IDLE. Max throughput: one word per WIDTH+2 cycles.
//  - Load while Ready=0: ignored, Data not sampled. Data changes after acceptance have no effect.
//  - Default bit order: LSB first (X = Data[0] first).
//  - Tallies:
//    - zero_cnt/one_cnt increment on each XValid cycle per X value.
//    - Saturate at MIN_ZEROS/MIN_ONES; width $clog2(max(MIN_ZEROS,MIN_ONES)+1). No wrap.
//  - Seen: registered; sets the cycle after the bit that completes both thresholds; stays 1 until Clear/reset.
//  - Clear=1: next edge zeroes tallies and Seen. If it coincides with a valid bit, Clear wins and that
//    bit is not counted. Clear does not affect the shift FSM.
//  - Output ordering: Seen may rise in the same cycle as Done.
// CONFIGURATION
//  - SERIAL_TX_MSB_FIRST_EN defined: bits leave MSB first (X = Data[WIDTH-1] first, shift left).
//  - Undefined: LSB first. Timing, handshake and tallies are identical in both builds.
// STRUCTURE
//  - Package serial_tx_pkg holds:
//    - typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_state_t
//    - function clog2-based tally width helper
//  - Sub-module bit_tally (params MIN_ZEROS, MIN_ONES):
//    - inputs: Clock, Resetn, Clear, BitValid, Bit
//    - output: Seen
//    - contains the saturating counters and sticky flag
//  - Top holds FSM, shift register, bit counter, handshake.
// TESTING
//  1. Reset then idle: Ready=1, X=0, XValid=0, Done=0, Seen=0; assert Resetn low mid-SHIFT
//     -> next cycle IDLE, XValid=0, no Done.
//  2. Load Data=8'b0111_0101 (LSB first) -> X=1,0,1,0,1,1,1,0 on 8 XValid cycles; Done pulses next
//     cycle; Seen rises after 4th bit.
//  3. Load 8'hFF then 8'h00 back-to-back (Load held high) -> second accepted only when Ready returns;
//     Seen=0 through first word, rises after 2nd zero of second word.
//  4. Load asserted with Data=8'hA5 during SHIFT -> ignored; stream matches first word only, one Done.
//  5. Clear pulsed in the cycle Seen would set -> Seen stays 0; tallies restart from next bit.
//  6. Build with SERIAL_TX_MSB_FIRST_EN, Data=8'b1000_0001 -> X=1,0,0,0,0,0,0,1; Seen after 2nd 1 (bit 8).

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and sizing helper for the serial pattern transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_state_t;

    // Tally counters only need to reach the larger threshold, then saturate.
    function automatic int tally_w(input int min_zeros, input int min_ones);
        int m;
        m = (min_zeros > min_ones) ? min_zeros : min_ones;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/serial_pattern_tx_bit_tally.sv
// Saturating zero/one tallies over valid serial bits with a sticky Seen flag.
module bit_tally
    import serial_tx_pkg::*;
#(
    parameter int MIN_ZEROS = 2,
    parameter int MIN_ONES  = 2
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic Clear,
    input  logic BitValid,
    input  logic Bit,
    output logic Seen
);

    localparam int TW = tally_w(MIN_ZEROS, MIN_ONES);
    localparam logic [TW-1:0] ZMAX = TW'(MIN_ZEROS);
    localparam logic [TW-1:0] OMAX = TW'(MIN_ONES);

    logic [TW-1:0] zero_cnt_q, zero_cnt_d;
    logic [TW-1:0] one_cnt_q, one_cnt_d;
    logic          seen_q, seen_d;

    always_comb begin
        zero_cnt_d = zero_cnt_q;
        one_cnt_d  = one_cnt_q;
        if (BitValid) begin
            if (Bit && one_cnt_q < OMAX)       one_cnt_d  = one_cnt_q + TW'(1);
            if (!Bit && zero_cnt_q < ZMAX)     zero_cnt_d = zero_cnt_q + TW'(1);
        end
        // Evaluated on the updated counts so Seen rises right after the completing bit.
        seen_d = seen_q | ((zero_cnt_d == ZMAX) && (one_cnt_d == OMAX));
        if (Clear) begin
            zero_cnt_d = '0;
            one_cnt_d  = '0;
            seen_d     = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            zero_cnt_q <= '0;
            one_cnt_q  <= '0;
            seen_q     <= 1'b0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
            one_cnt_q  <= one_cnt_d;
            seen_q     <= seen_d;
        end
    end

    assign Seen = seen_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-in, serial-out pattern transmitter with valid/ready load and bit tallies.
// Define SERIAL_TX_MSB_FIRST_EN to shift MSB first; default is LSB first.
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MIN_ZEROS = 2,
    parameter int MIN_ONES  = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data,
    input  logic             Clear,
    output logic             Ready,
    output logic             X,
    output logic             XValid,
    output logic             Done,
    output logic             Seen
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    tx_state_t        state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             ready_q, xvalid_q, done_q;

    // Zero fill means the register is all zeros once a word has fully left, keeping X low when idle.
`ifdef SERIAL_TX_MSB_FIRST_EN
    wire [WIDTH-1:0] shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
    assign X = shreg_q[WIDTH-1];
`else
    wire [WIDTH-1:0] shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
    assign X = shreg_q[0];
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            xvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Load && ready_q) begin
                        shreg_q  <= Data;
                        cnt_q    <= '0;
                        state_q  <= SHIFT;
                        ready_q  <= 1'b0;
                        xvalid_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    shreg_q <= shreg_next;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q  <= DONE;
                        xvalid_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q  <= IDLE;
                    shreg_q  <= '0;
                    ready_q  <= 1'b1;
                    xvalid_q <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign Ready  = ready_q;
    assign XValid = xvalid_q;
    assign Done   = done_q;

    bit_tally #(
        .MIN_ZEROS(MIN_ZEROS),
        .MIN_ONES (MIN_ONES)
    ) u_tally (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Clear   (Clear),
        .BitValid(xvalid_q),
        .Bit     (X),
        .Seen    (Seen)
    );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed self-checking bench for serial_pattern_tx (WIDTH=8, thresholds 2/2).
module tb_serial_pattern_tx;

    logic       Clock = 1'b0;
    logic       Resetn, Load, Clear;
    logic [7:0] Data;
    logic       Ready, X, XValid, Done, Seen;
    int         checks = 0;
    int         failures = 0;

    always #5 Clock = ~Clock;

    serial_pattern_tx #(.WIDTH(8), .MIN_ZEROS(2), .MIN_ONES(2)) dut (
        .Clock(Clock), .Resetn(Resetn), .Load(Load), .Data(Data), .Clear(Clear),
        .Ready(Ready), .X(X), .XValid(XValid), .Done(Done), .Seen(Seen)
    );

    task automatic accept(input logic [7:0] d);
        @(posedge Clock); #1 Load = 1'b1; Data = d;
        @(posedge Clock); #1 Load = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge Clock); #1 Clear = 1'b1;
        @(posedge Clock); #1 Clear = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        Resetn = 1'b0; Load = 1'b0; Clear = 1'b0; Data = '0;
        #12;
        checks++; if (Ready !== 1'b1)  begin failures++; $display("FAIL reset_ready got=%b exp=1", Ready); end
        checks++; if (X !== 1'b0)      begin failures++; $display("FAIL reset_x got=%b exp=0", X); end
        checks++; if (XValid !== 1'b0) begin failures++; $display("FAIL reset_xvalid got=%b exp=0", XValid); end
        checks++; if (Done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
        checks++; if (Seen !== 1'b0)   begin failures++; $display("FAIL reset_seen got=%b exp=0", Seen); end
        @(posedge Clock); #1 Resetn = 1'b1;
        @(negedge Clock);
        checks++; if ({Ready, XValid} !== 2'b10) begin failures++; $display("FAIL idle_after_reset got=%b exp=10", {Ready, XValid}); end
        // Abort a word mid-shift.
        accept(8'hFF);
        repeat (3) @(negedge Clock);
        checks++; if (XValid !== 1'b1) begin failures++; $display("FAIL midshift_active got=%b exp=1", XValid); end
        Resetn = 1'b0;
        #1;
        checks++; if ({Ready, XValid, X, Done} !== 4'b1000) begin failures++; $display("FAIL midshift_reset got=%b exp=1000", {Ready, XValid, X, Done}); end
        @(posedge Clock); #1 Resetn = 1'b1;
        bad = 0;
        repeat (12) begin @(negedge Clock); if (Done || XValid) bad++; end
        checks++; if (bad !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", bad); end
    endtask

    task automatic test_stream();
        logic [7:0] e;
        int seen_from;
`ifdef SERIAL_TX_MSB_FIRST_EN
        e = 8'b1010_1110; seen_from = 5;
`else
        e = 8'b0111_0101; seen_from = 4;
`endif
        accept(8'b0111_0101);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            checks++; if ({XValid, X, Ready, Done} !== {1'b1, e[i], 2'b00}) begin failures++; $display("FAIL stream_bit%0d got=%b exp=%b", i, {XValid, X, Ready, Done}, {1'b1, e[i], 2'b00}); end
            checks++; if (Seen !== (i >= seen_from)) begin failures++; $display("FAIL stream_seen%0d got=%b exp=%b", i, Seen, (i >= seen_from)); end
        end
        @(negedge Clock);
        checks++; if ({Done, XValid, Ready, Seen} !== 4'b1001) begin failures++; $display("FAIL stream_done got=%b exp=1001", {Done, XValid, Ready, Seen}); end
        @(negedge Clock);
        checks++; if ({Done, Ready} !== 2'b01) begin failures++; $display("FAIL stream_idle got=%b exp=01", {Done, Ready}); end
    endtask

    task automatic test_back_to_back();
        pulse_clear();
        @(negedge Clock);
        checks++; if (Seen !== 1'b0) begin failures++; $display("FAIL b2b_clear got=%b exp=0", Seen); end
        @(posedge Clock); #1 Load = 1'b1; Data = 8'hFF;
        @(posedge Clock); #1 Data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            checks++; if ({XValid, X, Ready, Seen} !== 4'b1100) begin failures++; $display("FAIL b2b_w1_bit%0d got=%b exp=1100", i, {XValid, X, Ready, Seen}); end
        end
        @(negedge Clock);
        checks++; if ({Done, Ready, Seen} !== 3'b100) begin failures++; $display("FAIL b2b_w1_done got=%b exp=100", {Done, Ready, Seen}); end
        @(negedge Clock);
        checks++; if ({Ready, XValid} !== 2'b10) begin failures++; $display("FAIL b2b_ready_gap got=%b exp=10", {Ready, XValid}); end
        @(posedge Clock); #1 Load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            checks++; if ({XValid, X} !== 2'b10) begin failures++; $display("FAIL b2b_w2_bit%0d got=%b exp=10", i, {XValid, X}); end
            checks++; if (Seen !== (i >= 2)) begin failures++; $display("FAIL b2b_w2_seen%0d got=%b exp=%b", i, Seen, (i >= 2)); end
        end
        @(negedge Clock);
        checks++; if ({Done, Seen} !== 2'b11) begin failures++; $display("FAIL b2b_w2_done got=%b exp=11", {Done, Seen}); end
    endtask

    task automatic test_load_ignored();
        logic [7:0] d;
        int extra;
        d = 8'h3C;  // palindrome: same stream in either bit order
        accept(d);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            checks++; if ({XValid, X} !== {1'b1, d[i]}) begin failures++; $display("FAIL ignore_bit%0d got=%b exp=%b", i, {XValid, X}, {1'b1, d[i]}); end
            if (i == 0) begin Load = 1'b1; Data = 8'hA5; end
        end
        @(negedge Clock);
        checks++; if ({Done, XValid} !== 2'b10) begin failures++; $display("FAIL ignore_done got=%b exp=10", {Done, XValid}); end
        Load = 1'b0;
        extra = 0;
        repeat (12) begin @(negedge Clock); if (Done || XValid) extra++; end
        checks++; if (extra !== 0) begin failures++; $display("FAIL ignore_single_done got=%0d exp=0", extra); end
    endtask

    task automatic test_clear();
        logic [7:0] d;
        d = 8'b1001_1001;  // palindrome
        pulse_clear();
        accept(d);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            checks++; if ({XValid, X, Seen} !== {1'b1, d[i], 1'b0}) begin failures++; $display("FAIL clear_bit%0d got=%b exp=%b", i, {XValid, X, Seen}, {1'b1, d[i], 1'b0}); end
            if (i == 3) Clear = 1'b1;
            if (i == 4) Clear = 1'b0;
        end
        @(negedge Clock);
        checks++; if ({Done, Seen} !== 2'b11) begin failures++; $display("FAIL clear_restart_seen got=%b exp=11", {Done, Seen}); end
    endtask

    task automatic test_msb_pattern();
        logic [7:0] d;
        d = 8'b1000_0001;
        pulse_clear();
        accept(d);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            checks++; if ({XValid, X, Seen} !== {1'b1, d[i], 1'b0}) begin failures++; $display("FAIL ends_bit%0d got=%b exp=%b", i, {XValid, X, Seen}, {1'b1, d[i], 1'b0}); end
        end
        @(negedge Clock);
        checks++; if ({Done, Seen} !== 2'b11) begin failures++; $display("FAIL ends_seen got=%b exp=11", {Done, Seen}); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_load_ignored();
        test_clear();
        test_msb_pattern();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
